mini_src_ctrl_seq: RTL and testbench

Hardwired control sequencer for the Mini-SRC datapath. It decodes the IR opcode and steps through fetch and execute micro-states, driving the datapath strobes: register select, bus drivers and register enables. Compared with the first-generation control unit it adds:
- exactly one clock per micro-step, with no delay-based pulse shaping;
- parametrised opcode field;
- a memory ready handshake with wait states;
- conditional branch short-circuit;
- a synchronous stop request honoured at instruction boundaries;
- illegal-opcode flagging.

---
 rtl/mini_src_pkg.sv | 91 +++++++++
 rtl/mini_src_ctrl_decode.sv | 106 ++++++++++
 rtl/mini_src_ctrl_seq.sv | 140 ++++++++++++++
 tb/tb_mini_src_ctrl_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini-SRC control sequencer: opcodes, state
// encoding, control vector layout and the opcode-to-execute-state map.
package mini_src_pkg;

    localparam logic [31:0] OP_LOAD   = 32'd0;
    localparam logic [31:0] OP_LOADI  = 32'd1;
    localparam logic [31:0] OP_STORE  = 32'd2;
    localparam logic [31:0] OP_ADD    = 32'd3;
    localparam logic [31:0] OP_SUB    = 32'd4;
    localparam logic [31:0] OP_SHR    = 32'd5;
    localparam logic [31:0] OP_SHRA   = 32'd6;
    localparam logic [31:0] OP_SHL    = 32'd7;
    localparam logic [31:0] OP_ROR    = 32'd8;
    localparam logic [31:0] OP_ROL    = 32'd9;
    localparam logic [31:0] OP_AND    = 32'd10;
    localparam logic [31:0] OP_OR     = 32'd11;
    localparam logic [31:0] OP_ADDI   = 32'd12;
    localparam logic [31:0] OP_ANDI   = 32'd13;
    localparam logic [31:0] OP_ORI    = 32'd14;
    localparam logic [31:0] OP_MUL    = 32'd15;
    localparam logic [31:0] OP_DIV    = 32'd16;
    localparam logic [31:0] OP_NEG    = 32'd17;
    localparam logic [31:0] OP_NOT    = 32'd18;
    localparam logic [31:0] OP_BRANCH = 32'd19;
    localparam logic [31:0] OP_JR     = 32'd20;
    localparam logic [31:0] OP_JAL    = 32'd21;
    localparam logic [31:0] OP_IN     = 32'd22;
    localparam logic [31:0] OP_OUT    = 32'd23;
    localparam logic [31:0] OP_MFHI   = 32'd24;
    localparam logic [31:0] OP_MFLO   = 32'd25;
    localparam logic [31:0] OP_NOP    = 32'd26;
    localparam logic [31:0] OP_HALT   = 32'd27;

    typedef enum logic [6:0] {
        ST_RESET   = 7'd0,
        ST_T0      = 7'd1,  ST_T1    = 7'd2,  ST_T2    = 7'd3,
        ST_ALU3    = 7'd4,  ST_ALU4  = 7'd5,  ST_ALU5  = 7'd6,
        ST_IMM3    = 7'd7,  ST_IMM4  = 7'd8,  ST_IMM5  = 7'd9,
        ST_MUL3    = 7'd10, ST_MUL4  = 7'd11, ST_MUL5  = 7'd12, ST_MUL6 = 7'd13,
        ST_NEG3    = 7'd14, ST_NEG4  = 7'd15,
        ST_LD3     = 7'd16, ST_LD4   = 7'd17, ST_LD5   = 7'd18, ST_LD6  = 7'd19,
        ST_LD7     = 7'd20,
        ST_LDI3    = 7'd21, ST_LDI4  = 7'd22, ST_LDI5  = 7'd23,
        ST_ST3     = 7'd24, ST_ST4   = 7'd25, ST_ST5   = 7'd26, ST_ST6  = 7'd27,
        ST_ST7     = 7'd28,
        ST_BR3     = 7'd29, ST_BR4   = 7'd30, ST_BR5   = 7'd31, ST_BR6  = 7'd32,
        ST_JAL3    = 7'd33, ST_JAL4  = 7'd34, ST_JAL5  = 7'd35,
        ST_JR3     = 7'd36, ST_IN3   = 7'd37, ST_OUT3  = 7'd38,
        ST_MFHI3   = 7'd39, ST_MFLO3 = 7'd40, ST_NOP3  = 7'd41,
        ST_HALT    = 7'd42, ST_ILLEGAL = 7'd43
    } state_t;

    typedef struct packed {
        logic gra;       logic grb;       logic grc;       logic rin;
        logic rout;      logic ba_out;    logic con_in;    logic pc_out;
        logic pc_in;     logic inc_pc;    logic mar_in;    logic mdr_in;
        logic mdr_out;   logic ir_in;     logic y_in;      logic zlow_in;
        logic zhigh_in;  logic zlow_out;  logic zhigh_out; logic c_out;
        logic hi_in;     logic hi_out;    logic lo_in;     logic lo_out;
        logic in_port_out; logic out_port_in; logic read;  logic write;
        logic jal_flag;  logic run;       logic illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(31'd0);

    function automatic state_t first_exec_state(input logic [31:0] opc);
        state_t st;
        case (opc)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  st = ST_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:       st = ST_IMM3;
            OP_MUL, OP_DIV:                 st = ST_MUL3;
            OP_NEG, OP_NOT:                 st = ST_NEG3;
            OP_LOAD:                        st = ST_LD3;
            OP_LOADI:                       st = ST_LDI3;
            OP_STORE:                       st = ST_ST3;
            OP_BRANCH:                      st = ST_BR3;
            OP_JAL:                         st = ST_JAL3;
            OP_JR:                          st = ST_JR3;
            OP_IN:                          st = ST_IN3;
            OP_OUT:                         st = ST_OUT3;
            OP_MFHI:                        st = ST_MFHI3;
            OP_MFLO:                        st = ST_MFLO3;
            OP_NOP:                         st = ST_NOP3;
            OP_HALT:                        st = ST_HALT;
            default:                        st = ST_ILLEGAL;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mini_src_ctrl_decode.sv
// Pure state-to-control-vector decode; every strobe depends only on the
// current state so the controller behaves as a Moore machine.
module mini_src_ctrl_decode
    import mini_src_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Strobe set for each micro-state; anything unlisted stays low
    always_comb begin
        ctrl     = CTRL_NONE;
        ctrl.run = 1'b1;
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1; ctrl.pc_in  = 1'b1;
            end
            ST_T1, ST_LD6: begin
                ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_ALU3, ST_IMM3: begin
                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
            end
            ST_ALU4: begin
                ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zlow_in = 1'b1;
            end
            ST_IMM4, ST_LD4, ST_LDI4, ST_ST4, ST_BR5: begin
                ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1;
            end
            ST_ALU5, ST_IMM5, ST_NEG4, ST_LDI5: begin
                ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
            end
            ST_MUL3: begin
                ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
            end
            ST_MUL4: begin
                ctrl.grb = 1'b1; ctrl.rout = 1'b1;
                ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
            end
            ST_MUL5: begin
                ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
            end
            ST_MUL6: begin
                ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
            end
            ST_NEG3: begin
                ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zlow_in = 1'b1;
            end
            ST_LD3, ST_LDI3, ST_ST3: begin
                ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ST_LD5, ST_ST5: begin
                ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
            end
            ST_LD7: begin
                ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
            end
            ST_ST6: begin
                ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_ST7: begin
                ctrl.mdr_out = 1'b1; ctrl.write = 1'b1;
            end
            ST_BR3: begin
                ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1;
            end
            ST_BR4: begin
                ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ST_BR6: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1;
            end
            // Return address is staged through Z before landing in R15
            ST_JAL3: begin
                ctrl.pc_out = 1'b1; ctrl.zlow_in = 1'b1;
            end
            ST_JAL4: begin
                ctrl.zlow_out = 1'b1; ctrl.jal_flag = 1'b1; ctrl.rin = 1'b1;
            end
            ST_JAL5, ST_JR3: begin
                ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1;
            end
            ST_IN3: begin
                ctrl.gra = 1'b1; ctrl.rin = 1'b1; ctrl.in_port_out = 1'b1;
            end
            ST_OUT3: begin
                ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.out_port_in = 1'b1;
            end
            ST_MFHI3: begin
                ctrl.gra = 1'b1; ctrl.rin = 1'b1; ctrl.hi_out = 1'b1;
            end
            ST_MFLO3: begin
                ctrl.gra = 1'b1; ctrl.rin = 1'b1; ctrl.lo_out = 1'b1;
            end
            ST_HALT:    ctrl.run = 1'b0;
            ST_ILLEGAL: ctrl.illegal_op = 1'b1;
            ST_RESET, ST_NOP3: ctrl.run = 1'b1;
            default:    ctrl.run = 1'b1;
        endcase
    end

endmodule

// File: rtl/mini_src_ctrl_seq.sv
// Hardwired Mini-SRC control sequencer: state register, next-state logic,
// memory wait handshake, branch short-circuit and stop handling.
module mini_src_ctrl_seq
    import mini_src_pkg::*;
#(
    parameter int IR_W             = 32'd32,
    parameter int OPC_W            = 32'd5,
    parameter int OPC_LSB          = 32'd27,
    parameter bit MEM_HS           = 1'b1,
    parameter bit BR_SKIP          = 1'b1,
    parameter bit STOP_AT_BOUNDARY = 1'b1
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] IR,
    input  logic            mem_done,
    input  logic            con_ff,
    input  logic            stop,
    output logic Gra, Grb, Grc, Rin, Rout, BAout, CONin,
    output logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
    output logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, Cout,
    output logic HIin, HIout, LOin, LOout,
    output logic InPortout, OutPortin,
    output logic Read, Write,
    output logic JAL_flag,
    output logic Run,
    output logic illegal_op,
    output logic [6:0] state_out
);

    state_t      state_r;
    state_t      nat_s;
    state_t      state_next_s;
    logic        mem_ok_s;
    logic [31:0] opc_s;
    ctrl_t       ctrl_s;
    logic        unused_ir_s;

    assign opc_s       = 32'(IR[OPC_LSB +: OPC_W]);
    assign unused_ir_s = ^IR;
    assign mem_ok_s    = (MEM_HS == 1'b0) || mem_done;

    // Natural successor of each micro-state, then stop overrides
    always_comb begin
        nat_s = ST_RESET;
        case (state_r)
            ST_RESET:   nat_s = ST_T0;
            ST_T0:      nat_s = ST_T1;
            ST_T1:      nat_s = mem_ok_s ? ST_T2 : ST_T1;
            ST_T2:      nat_s = first_exec_state(opc_s);
            ST_ALU3:    nat_s = ST_ALU4;
            ST_ALU4:    nat_s = ST_ALU5;
            ST_IMM3:    nat_s = ST_IMM4;
            ST_IMM4:    nat_s = ST_IMM5;
            ST_MUL3:    nat_s = ST_MUL4;
            ST_MUL4:    nat_s = ST_MUL5;
            ST_MUL5:    nat_s = ST_MUL6;
            ST_NEG3:    nat_s = ST_NEG4;
            ST_LD3:     nat_s = ST_LD4;
            ST_LD4:     nat_s = ST_LD5;
            ST_LD5:     nat_s = ST_LD6;
            ST_LD6:     nat_s = mem_ok_s ? ST_LD7 : ST_LD6;
            ST_LDI3:    nat_s = ST_LDI4;
            ST_LDI4:    nat_s = ST_LDI5;
            ST_ST3:     nat_s = ST_ST4;
            ST_ST4:     nat_s = ST_ST5;
            ST_ST5:     nat_s = ST_ST6;
            ST_ST6:     nat_s = ST_ST7;
            ST_ST7:     nat_s = mem_ok_s ? ST_T0 : ST_ST7;
            ST_BR3:     nat_s = ST_BR4;
            // Not-taken branch skips the target computation entirely
            ST_BR4:     nat_s = ((BR_SKIP == 1'b1) && !con_ff) ? ST_T0 : ST_BR5;
            ST_BR5:     nat_s = ST_BR6;
            ST_JAL3:    nat_s = ST_JAL4;
            ST_JAL4:    nat_s = ST_JAL5;
            ST_ALU5, ST_IMM5, ST_MUL6, ST_NEG4, ST_LD7, ST_LDI5, ST_BR6,
            ST_JAL5, ST_JR3, ST_IN3, ST_OUT3, ST_MFHI3, ST_MFLO3, ST_NOP3,
            ST_ILLEGAL: nat_s = ST_T0;
            ST_HALT:    nat_s = ST_HALT;
            default:    nat_s = ST_RESET;
        endcase

        state_next_s = nat_s;
        if ((STOP_AT_BOUNDARY == 1'b0) && stop) begin
            state_next_s = ST_HALT;
        end else if ((STOP_AT_BOUNDARY == 1'b1) && stop && (nat_s == ST_T0)) begin
            state_next_s = ST_HALT;
        end else begin
            state_next_s = nat_s;
        end
    end

    // State register; clear forces RESET without waiting for a clock edge
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    mini_src_ctrl_decode u_decode (
        .state (state_r),
        .ctrl  (ctrl_s)
    );

    assign Gra        = ctrl_s.gra;
    assign Grb        = ctrl_s.grb;
    assign Grc        = ctrl_s.grc;
    assign Rin        = ctrl_s.rin;
    assign Rout       = ctrl_s.rout;
    assign BAout      = ctrl_s.ba_out;
    assign CONin      = ctrl_s.con_in;
    assign PCout      = ctrl_s.pc_out;
    assign PCin       = ctrl_s.pc_in;
    assign IncPC      = ctrl_s.inc_pc;
    assign MARin      = ctrl_s.mar_in;
    assign MDRin      = ctrl_s.mdr_in;
    assign MDRout     = ctrl_s.mdr_out;
    assign IRin       = ctrl_s.ir_in;
    assign Yin        = ctrl_s.y_in;
    assign Zlowin     = ctrl_s.zlow_in;
    assign Zhighin    = ctrl_s.zhigh_in;
    assign Zlowout    = ctrl_s.zlow_out;
    assign Zhighout   = ctrl_s.zhigh_out;
    assign Cout       = ctrl_s.c_out;
    assign HIin       = ctrl_s.hi_in;
    assign HIout      = ctrl_s.hi_out;
    assign LOin       = ctrl_s.lo_in;
    assign LOout      = ctrl_s.lo_out;
    assign InPortout  = ctrl_s.in_port_out;
    assign OutPortin  = ctrl_s.out_port_in;
    assign Read       = ctrl_s.read;
    assign Write      = ctrl_s.write;
    assign JAL_flag   = ctrl_s.jal_flag;
    assign Run        = ctrl_s.run;
    assign illegal_op = ctrl_s.illegal_op;
    assign state_out  = state_r;

endmodule

// File: tb/tb_mini_src_ctrl_seq.sv
// Self-checking bench for mini_src_ctrl_seq: per-instruction strobe-sequence
// model built from the ISA step tables, with random opcodes and wait states.
module tb_mini_src_ctrl_seq;
    import mini_src_pkg::*;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = 32'd0;
    logic        mem_done = 1'b0, con_ff = 1'b0, stop = 1'b0;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CONin, PCout, PCin, IncPC, MARin;
    logic MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, Cout;
    logic HIin, HIout, LOin, LOout, InPortout, OutPortin, Read, Write;
    logic JAL_flag, Run, illegal_op;
    logic [6:0] state_out;
    logic [30:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [30:0] M_GRA = 31'd1 << 30, M_GRB = 31'd1 << 29, M_GRC = 31'd1 << 28;
    localparam logic [30:0] M_RIN = 31'd1 << 27, M_ROUT = 31'd1 << 26, M_BAOUT = 31'd1 << 25;
    localparam logic [30:0] M_CONIN = 31'd1 << 24, M_PCOUT = 31'd1 << 23, M_PCIN = 31'd1 << 22;
    localparam logic [30:0] M_INCPC = 31'd1 << 21, M_MARIN = 31'd1 << 20, M_MDRIN = 31'd1 << 19;
    localparam logic [30:0] M_MDROUT = 31'd1 << 18, M_IRIN = 31'd1 << 17, M_YIN = 31'd1 << 16;
    localparam logic [30:0] M_ZLI = 31'd1 << 15, M_ZHI = 31'd1 << 14, M_ZLO = 31'd1 << 13;
    localparam logic [30:0] M_ZHO = 31'd1 << 12, M_COUT = 31'd1 << 11, M_HIIN = 31'd1 << 10;
    localparam logic [30:0] M_HIOUT = 31'd1 << 9, M_LOIN = 31'd1 << 8, M_LOOUT = 31'd1 << 7;
    localparam logic [30:0] M_INP = 31'd1 << 6, M_OUTP = 31'd1 << 5, M_READ = 31'd1 << 4;
    localparam logic [30:0] M_WRITE = 31'd1 << 3, M_JAL = 31'd1 << 2, M_RUN = 31'd1 << 1;
    localparam logic [30:0] M_ILL = 31'd1;

    assign obs = {Gra, Grb, Grc, Rin, Rout, BAout, CONin, PCout, PCin, IncPC, MARin,
                  MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, Cout,
                  HIin, HIout, LOin, LOout, InPortout, OutPortin, Read, Write,
                  JAL_flag, Run, illegal_op};

    mini_src_ctrl_seq #(
        .IR_W(32), .OPC_W(5), .OPC_LSB(27),
        .MEM_HS(1'b1), .BR_SKIP(1'b1), .STOP_AT_BOUNDARY(1'b1)
    ) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_done(mem_done),
        .con_ff(con_ff), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CONin(CONin), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Cout(Cout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .InPortout(InPortout), .OutPortin(OutPortin), .Read(Read), .Write(Write),
        .JAL_flag(JAL_flag), .Run(Run), .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clock = ~clock;

    // Execute-step count per opcode (full length, before any branch skip)
    function automatic int n_steps(input int opc);
        case (opc)
            0, 2:                     return 5;
            1, 12, 13, 14, 21:        return 3;
            3, 4, 5, 6, 7, 8, 9, 10, 11: return 3;
            15, 16, 19:               return 4;
            17, 18:                   return 2;
            default:                  return 1;
        endcase
    endfunction

    // Index of the step that waits for memory, -1 if none
    function automatic int mem_step(input int opc);
        if (opc == 0) return 3;
        else if (opc == 2) return 4;
        else return -1;
    endfunction

    // ISA signal set of execute step k of an opcode
    function automatic logic [30:0] exec_mask(input int opc, input int k);
        logic [30:0] addr [3];
        addr[0] = M_GRB | M_BAOUT | M_YIN;
        addr[1] = M_COUT | M_ZLI;
        addr[2] = M_ZLO | M_MARIN;
        case (opc)
            3, 4, 5, 6, 7, 8, 9, 10, 11:
                return (k == 0) ? (M_GRB | M_ROUT | M_YIN) :
                       (k == 1) ? (M_GRC | M_ROUT | M_ZLI) : (M_ZLO | M_GRA | M_RIN);
            12, 13, 14:
                return (k == 0) ? (M_GRB | M_ROUT | M_YIN) :
                       (k == 1) ? (M_COUT | M_ZLI) : (M_ZLO | M_GRA | M_RIN);
            15, 16:
                return (k == 0) ? (M_GRA | M_ROUT | M_YIN) :
                       (k == 1) ? (M_GRB | M_ROUT | M_ZLI | M_ZHI) :
                       (k == 2) ? (M_ZLO | M_LOIN) : (M_ZHO | M_HIIN);
            17, 18: return (k == 0) ? (M_GRB | M_ROUT | M_ZLI) : (M_ZLO | M_GRA | M_RIN);
            0:  return (k < 3) ? addr[k] : (k == 3) ? (M_READ | M_MDRIN) : (M_MDROUT | M_GRA | M_RIN);
            1:  return (k < 2) ? addr[k] : (M_ZLO | M_GRA | M_RIN);
            2:  return (k < 3) ? addr[k] : (k == 3) ? (M_GRA | M_ROUT | M_MDRIN) : (M_MDROUT | M_WRITE);
            19: return (k == 0) ? (M_GRA | M_ROUT | M_CONIN) : (k == 1) ? (M_PCOUT | M_YIN) :
                       (k == 2) ? (M_COUT | M_ZLI) : (M_ZLO | M_PCIN);
            21: return (k == 0) ? (M_PCOUT | M_ZLI) : (k == 1) ? (M_ZLO | M_JAL | M_RIN) :
                       (M_GRA | M_ROUT | M_PCIN);
            20: return M_GRA | M_ROUT | M_PCIN;
            22: return M_GRA | M_RIN | M_INP;
            23: return M_GRA | M_ROUT | M_OUTP;
            24: return M_GRA | M_RIN | M_HIOUT;
            25: return M_GRA | M_RIN | M_LOOUT;
            26: return 31'd0;
            default: return M_ILL;
        endcase
    endfunction

    // Runs one instruction from T0, checking every cycle's strobes.
    // stop_k >= 0 raises stop in that execute step; abort clears mid memory step.
    task automatic run_instr(input int opc, input bit con, input int w_fetch,
                             input int w_mem, input int stop_k, input bit abort,
                             input string name);
        logic [30:0] eq[$];
        bit          mq[$];
        int          kq[$];
        int          n, mi;
        logic [4:0]  o5;
        n  = n_steps(opc);
        mi = mem_step(opc);
        if (opc == 19 && !con) n = 2;
        eq.push_back(M_PCOUT | M_MARIN | M_INCPC | M_PCIN); mq.push_back(1'($urandom_range(0, 1))); kq.push_back(-1);
        for (int i = 0; i <= w_fetch; i++) begin
            eq.push_back(M_READ | M_MDRIN); mq.push_back(i == w_fetch); kq.push_back(-1);
        end
        eq.push_back(M_MDROUT | M_IRIN); mq.push_back(1'($urandom_range(0, 1))); kq.push_back(-1);
        for (int k = 0; k < n; k++) begin
            if (k == mi) begin
                for (int i = 0; i <= w_mem; i++) begin
                    eq.push_back(exec_mask(opc, k)); mq.push_back(i == w_mem); kq.push_back(k);
                end
            end else begin
                eq.push_back(exec_mask(opc, k)); mq.push_back(1'($urandom_range(0, 1))); kq.push_back(k);
            end
        end
        o5 = 5'(opc);
        IR = {o5, 27'($urandom)};
        con_ff = con;
        checks++;
        if (state_out !== ST_T0) begin
            errors++;
            $display("FAIL %s start_state opc=%0d: got %0d expected %0d", name, opc, state_out, ST_T0);
        end
        for (int i = 0; i < eq.size(); i++) begin
            checks++;
            if (obs !== (eq[i] | M_RUN)) begin
                errors++;
                $display("FAIL %s strobes opc=%0d cycle=%0d: got %h expected %h",
                         name, opc, i, obs, eq[i] | M_RUN);
            end
            if (abort && kq[i] == mi) begin
                mem_done = 1'b0;
                #3 clear = 1'b1;
                #1;
                checks++;
                if (obs !== M_RUN || state_out !== ST_RESET) begin
                    errors++;
                    $display("FAIL %s async_clear: got %h/%0d expected %h/%0d",
                             name, obs, state_out, M_RUN, ST_RESET);
                end
                #2 clear = 1'b0;
                @(posedge clock); #1;
                return;
            end
            if (kq[i] == stop_k && stop_k >= 0) stop = 1'b1;
            mem_done = mq[i];
            @(posedge clock); #1;
        end
        if (stop_k >= 0) begin
            stop = 1'b0;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (obs !== 31'd0 || state_out !== ST_HALT) begin
                    errors++;
                    $display("FAIL %s halt cycle=%0d: got %h/%0d expected %h/%0d",
                             name, c, obs, state_out, 31'd0, ST_HALT);
                end
                @(posedge clock); #1;
            end
            #3 clear = 1'b1;
            #1;
            checks++;
            if (obs !== M_RUN || state_out !== ST_RESET) begin
                errors++;
                $display("FAIL %s halt_clear: got %h/%0d expected %h/%0d",
                         name, obs, state_out, M_RUN, ST_RESET);
            end
            #2 clear = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        #1 clear = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (obs !== M_RUN || state_out !== ST_RESET) begin
            errors++;
            $display("FAIL reset: got %h/%0d expected %h/%0d", obs, state_out, M_RUN, ST_RESET);
        end
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_alu();
        run_instr(3, 1'b0, 0, 0, -1, 1'b0, "add");
        run_instr(15, 1'b0, 1, 0, -1, 1'b0, "mul");
        run_instr(17, 1'b0, 0, 0, -1, 1'b0, "neg");
    endtask

    task automatic test_load_wait();
        run_instr(0, 1'b0, 3, 3, -1, 1'b0, "ld_wait");
        run_instr(2, 1'b0, 0, 0, -1, 1'b0, "st_nowait");
    endtask

    task automatic test_branch();
        run_instr(19, 1'b0, 0, 0, -1, 1'b0, "br_not_taken");
        run_instr(19, 1'b1, 0, 0, -1, 1'b0, "br_taken");
    endtask

    task automatic test_illegal();
        run_instr(31, 1'b0, 0, 0, -1, 1'b0, "illegal31");
        run_instr(28, 1'b0, 2, 0, -1, 1'b0, "illegal28");
    endtask

    task automatic test_random();
        int opc;
        for (int t = 0; t < 60; t++) begin
            opc = $urandom_range(0, 31);
            if (opc == 27) opc = 26;
            run_instr(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1, 1'b0, "random");
        end
    endtask

    task automatic test_stop();
        run_instr(15, 1'b0, 0, 0, 1, 1'b0, "stop_mul");
        run_instr(26, 1'b0, 0, 0, -1, 1'b0, "after_stop");
    endtask

    task automatic test_store_clear();
        run_instr(2, 1'b0, 0, 3, -1, 1'b1, "st_clear");
        run_instr(21, 1'b0, 0, 0, -1, 1'b0, "jal_after_clear");
    endtask

    task automatic test_back_to_back();
        run_instr(1, 1'b0, 0, 0, -1, 1'b0, "ldi");
        run_instr(20, 1'b0, 0, 0, -1, 1'b0, "jr");
        run_instr(22, 1'b0, 0, 0, -1, 1'b0, "in");
        run_instr(25, 1'b0, 0, 0, -1, 1'b0, "mflo");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_illegal();
        test_stop();
        test_store_clear();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
